// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel-enable divider plus horizontal/vertical counters, all outputs registered.
// Define VGA_SYNC_DELAY_EN to delay hsync/vsync by one extra CLK stage so they line up with registered colour.
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        CLK,
  input  logic        RST,
  output logic [31:0] row,
  output logic [31:0] col,
  output logic        hsync,
  output logic        vsync,
  output logic        active,
  output logic        vnotactive,
  output logic        pix_en,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);

  // Decode bounds kept at 32 bits: a sync window may end exactly at the total.
  localparam logic [31:0] H_ACT    = 32'(H_ACTIVE);
  localparam logic [31:0] HS_START = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] HS_END   = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] V_ACT    = 32'(V_ACTIVE);
  localparam logic [31:0] VS_START = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] VS_END   = 32'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] divcnt_q, divcnt_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic          active_q, active_d;
  logic          vnotactive_q, vnotactive_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          pix_en_q, pix_en_d;
  logic          frame_start_q, frame_start_d;
  logic          advance;
  logic [31:0]   h_ext, v_ext;

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path can leave it unassigned and infer a latch.
    advance  = (divcnt_q == DIV_LAST);
    divcnt_d = advance ? '0 : divcnt_q + DW'(1);
    hcnt_d   = hcnt_q;
    vcnt_d   = vcnt_q;
    if (advance) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + VW'(1);
      end else begin
        hcnt_d = hcnt_q + HW'(1);
      end
    end

    // Flags decode the next-state counters so they land on the same edge as row/col.
    h_ext         = 32'(hcnt_d);
    v_ext         = 32'(vcnt_d);
    active_d      = (h_ext < H_ACT) && (v_ext < V_ACT);
    vnotactive_d  = (v_ext >= V_ACT);
    hsync_d       = (h_ext >= HS_START && h_ext < HS_END) ? SYNC_POL : ~SYNC_POL;
    vsync_d       = (v_ext >= VS_START && v_ext < VS_END) ? SYNC_POL : ~SYNC_POL;
    pix_en_d      = advance;
    frame_start_d = advance && (hcnt_q == H_LAST) && (vcnt_q == V_LAST);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      divcnt_q      <= '0;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      active_q      <= 1'b1;
      vnotactive_q  <= 1'b0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      pix_en_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      divcnt_q      <= divcnt_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      active_q      <= active_d;
      vnotactive_q  <= vnotactive_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      pix_en_q      <= pix_en_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef VGA_SYNC_DELAY_EN
  logic hsync_dly_q, hsync_dly_d;
  logic vsync_dly_q, vsync_dly_d;

  always_comb begin
    hsync_dly_d = hsync_q;
    vsync_dly_d = vsync_q;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      hsync_dly_q <= ~SYNC_POL;
      vsync_dly_q <= ~SYNC_POL;
    end else begin
      hsync_dly_q <= hsync_dly_d;
      vsync_dly_q <= vsync_dly_d;
    end
  end

  assign hsync = hsync_dly_q;
  assign vsync = vsync_dly_q;
`else
  assign hsync = hsync_q;
  assign vsync = vsync_q;
`endif

  assign row         = 32'(vcnt_q);
  assign col         = 32'(hcnt_q);
  assign active      = active_q;
  assign vnotactive  = vnotactive_q;
  assign pix_en      = pix_en_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: three parameterisations checked every cycle against a closed-form
// raster model, plus directed checks on sync width, mid-pixel async reset and frame_start period.
module tb_vga_timing_gen;

  typedef struct {
    int div, hact, hfp, hsy, hbp, vact, vfp, vsy, vbp;
    bit pol;
  } cfg_t;

  typedef struct packed {
    logic [31:0] row;
    logic [31:0] col;
    logic        hs, vs, act, vna, pe, fs;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int k        = 0;
  int n_compared = 0;

  logic [31:0] d0_row, d0_col, d1_row, d1_col, d2_row, d2_col;
  logic d0_hs, d0_vs, d0_act, d0_vna, d0_pe, d0_fs;
  logic d1_hs, d1_vs, d1_act, d1_vna, d1_pe, d1_fs;
  logic d2_hs, d2_vs, d2_act, d2_vna, d2_pe, d2_fs;
  exp_t o0, o1, o2;

  assign o0 = {d0_row, d0_col, d0_hs, d0_vs, d0_act, d0_vna, d0_pe, d0_fs};
  assign o1 = {d1_row, d1_col, d1_hs, d1_vs, d1_act, d1_vna, d1_pe, d1_fs};
  assign o2 = {d2_row, d2_col, d2_hs, d2_vs, d2_act, d2_vna, d2_pe, d2_fs};

  vga_timing_gen dut_def (
    .CLK(CLK), .RST(RST), .row(d0_row), .col(d0_col), .hsync(d0_hs), .vsync(d0_vs),
    .active(d0_act), .vnotactive(d0_vna), .pix_en(d0_pe), .frame_start(d0_fs)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b0)
  ) dut_sml (
    .CLK(CLK), .RST(RST), .row(d1_row), .col(d1_col), .hsync(d1_hs), .vsync(d1_vs),
    .active(d1_act), .vnotactive(d1_vna), .pix_en(d1_pe), .frame_start(d1_fs)
  );

  vga_timing_gen #(
    .CLK_DIV(3), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1)
  ) dut_mid (
    .CLK(CLK), .RST(RST), .row(d2_row), .col(d2_col), .hsync(d2_hs), .vsync(d2_vs),
    .active(d2_act), .vnotactive(d2_vna), .pix_en(d2_pe), .frame_start(d2_fs)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic cfg_t get_cfg(input int id);
    cfg_t c;
    case (id)
      0:       c = '{2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0};
      1:       c = '{1, 4, 1, 1, 1, 2, 1, 1, 1, 1'b0};
      default: c = '{3, 8, 2, 3, 2, 4, 1, 2, 1, 1'b1};
    endcase
    return c;
  endfunction

  // Sync levels after k edges since reset release, derived from the elapsed pixel count.
  function automatic logic [1:0] sync_at(input cfg_t c, input int kk);
    int n, ht, vt, h, v;
    logic hs, vs;
    if (kk < 0) kk = 0;
    ht = c.hact + c.hfp + c.hsy + c.hbp;
    vt = c.vact + c.vfp + c.vsy + c.vbp;
    n  = kk / c.div;
    h  = n % ht;
    v  = (n / ht) % vt;
    hs = (h >= c.hact + c.hfp && h < c.hact + c.hfp + c.hsy) ? c.pol : !c.pol;
    vs = (v >= c.vact + c.vfp && v < c.vact + c.vfp + c.vsy) ? c.pol : !c.pol;
    return {hs, vs};
  endfunction

  function automatic exp_t model(input cfg_t c, input int kk);
    exp_t e;
    int n, ht, vt, h, v;
    logic [1:0] s;
    ht = c.hact + c.hfp + c.hsy + c.hbp;
    vt = c.vact + c.vfp + c.vsy + c.vbp;
    n  = kk / c.div;
    h  = n % ht;
    v  = (n / ht) % vt;
`ifdef VGA_SYNC_DELAY_EN
    s = sync_at(c, kk - 1);
`else
    s = sync_at(c, kk);
`endif
    e.row = 32'(v);
    e.col = 32'(h);
    e.hs  = s[1];
    e.vs  = s[0];
    e.act = (h < c.hact) && (v < c.vact);
    e.vna = (v >= c.vact);
    e.pe  = (kk > 0) && (kk % c.div == 0);
    e.fs  = e.pe && (n > 0) && (n % (ht * vt) == 0);
    return e;
  endfunction

  function automatic exp_t reset_exp(input bit pol);
    exp_t e;
    e = '{row: 32'd0, col: 32'd0, hs: !pol, vs: !pol, act: 1'b1, vna: 1'b0, pe: 1'b0, fs: 1'b0};
    return e;
  endfunction

  task automatic compare_dut(input string nm, input exp_t o, input exp_t e);
    check({nm, ".row"},         64'(o.row), 64'(e.row));
    check({nm, ".col"},         64'(o.col), 64'(e.col));
    check({nm, ".hsync"},       64'(o.hs),  64'(e.hs));
    check({nm, ".vsync"},       64'(o.vs),  64'(e.vs));
    check({nm, ".active"},      64'(o.act), 64'(e.act));
    check({nm, ".vnotactive"},  64'(o.vna), 64'(e.vna));
    check({nm, ".pix_en"},      64'(o.pe),  64'(e.pe));
    check({nm, ".frame_start"}, 64'(o.fs),  64'(e.fs));
  endtask

  task automatic check_reset(input string phase);
    compare_dut({phase, ".def"}, o0, reset_exp(1'b0));
    compare_dut({phase, ".sml"}, o1, reset_exp(1'b0));
    compare_dut({phase, ".mid"}, o2, reset_exp(1'b1));
  endtask

  exp_t q0[$], q1[$], q2[$];

  // Stimulus side: each clock edge out of reset pushes the expected post-edge outputs.
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      k = 0;
      q0.delete();
      q1.delete();
      q2.delete();
    end else begin
      k++;
      q0.push_back(model(get_cfg(0), k));
      q1.push_back(model(get_cfg(1), k));
      q2.push_back(model(get_cfg(2), k));
    end
  end

  // Response side: compare on the falling edge, away from the active edge.
  always @(negedge CLK) begin
    if (RST) begin
      if (q0.size() > 0) begin compare_dut("def", o0, q0.pop_front()); n_compared++; end
      if (q1.size() > 0) begin compare_dut("sml", o1, q1.pop_front()); n_compared++; end
      if (q2.size() > 0) begin compare_dut("mid", o2, q2.pop_front()); n_compared++; end
    end
  end

  // Counts CLK edges until the chosen instance raises frame_start, bounded by limit.
  task automatic wait_fs(input int id, input int limit, output int cycles);
    logic seen;
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles <= limit) begin
      @(posedge CLK);
      cycles++;
      #1;
      seen = (id == 1) ? d1_fs : d2_fs;
    end
  endtask

  initial begin
    int hs_low;
    int cyc;
    bit found;

    RST = 1'b0;
    repeat (5) @(negedge CLK);
    check_reset("in_reset");
    #2 RST = 1'b1;

    // First lines of the default raster: hsync must be low for 96 pixels x 2 CLKs on row 0.
    hs_low = 0;
    for (int i = 0; i < 3300; i++) begin
      @(negedge CLK);
      if (d0_row == 32'd0 && d0_hs == 1'b0) hs_low++;
    end
    check("def.hsync_low_clks_row0", 64'(hs_low), 64'd192);

    // Walk to row 2, col 300 and pull reset in the middle of that pixel.
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(posedge CLK);
      #1;
      if (d0_row == 32'd2 && d0_col == 32'd300) found = 1'b1;
    end
    check("def.reached_r2c300", 64'(found), 64'd1);
    @(posedge CLK);
    #3 RST = 1'b0;
    #1 check_reset("async_reset");
    repeat (3) @(negedge CLK);
    check_reset("held_reset");
    #2 RST = 1'b1;

    // frame_start timing after release: first pulse one full frame later, then periodic.
    wait_fs(1, 200, cyc);
    check("sml.first_frame_start_clks", 64'(cyc), 64'd35);
    wait_fs(1, 200, cyc);
    check("sml.frame_start_period", 64'(cyc), 64'd35);
    wait_fs(2, 1000, cyc);
    check("mid.first_frame_start_k", 64'(k), 64'd360);
    wait_fs(2, 1000, cyc);
    check("mid.frame_start_period", 64'(cyc), 64'd360);

    repeat (4) @(negedge CLK);
    check("sb.compared_enough", 64'(n_compared > 3000), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Raster timing generator that sits directly upstream of the cell/border colour renderer. It produces the pixel coordinates (row, col) consumed by the renderer, plus the hsync/vsync pins, an active-video flag and the vertical-blanking flag that gates game-state updates. It is built from a pixel-enable divider and horizontal/vertical counters, with all outputs registered.

Parameters:
CLK_DIV, 2, CLK cycles per pixel (>=1); 50 MHz CLK gives a 25 MHz pixel rate
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)

Ports:
CLK  input  1  system clock
RST  input  1  reset, asynchronous, active-low
row  output  32  current line index, zero-extended vcnt
col  output  32  current pixel index, zero-extended hcnt
hsync  output  1  horizontal sync to the connector
vsync  output  1  vertical sync to the connector
active  output  1  high when hcnt<H_ACTIVE and vcnt<V_ACTIVE
vnotactive  output  1  high when vcnt>=V_ACTIVE (vertical blanking)
pix_en  output  1  one-CLK strobe marking the first cycle of each new pixel
frame_start  output  1  one-CLK pulse when the counters wrap to (0,0)

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Reset (RST low, takes effect immediately, asynchronous):
  - divcnt=0, hcnt=0, vcnt=0
  - row=0, col=0, active=1, vnotactive=0
  - hsync=vsync=~SYNC_POL
  - pix_en=0, frame_start=0
- Divider: divcnt counts 0..CLK_DIV-1 and wraps. An "advance edge" is a CLK edge at which divcnt wraps to 0. With CLK_DIV=1, every edge is an advance edge.
- On an advance edge:
  - hcnt increments.
  - If hcnt==H_TOTAL-1, hcnt goes to 0 and vcnt increments.
  - If vcnt==V_TOTAL-1 at that wrap, vcnt goes to 0.
- Output timing:
  - All outputs are registered and decoded from the next-state counters. On the edge where hcnt becomes N, col==N and hsync/active reflect N. Row and vcnt-derived outputs behave the same way.
  - There is no extra lag between coordinates and flags.
- pix_en is 1 for exactly the CLK cycle following each advance edge, 0 otherwise. With CLK_DIV=1 it is constantly 1 from the first edge after reset release.
- hsync is asserted (=SYNC_POL) for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]. vsync is asserted for vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]. vsync changes only at line wrap.
- frame_start is 1 for exactly one CLK following the advance edge where (hcnt,vcnt) wrap from (H_TOTAL-1,V_TOTAL-1) to (0,0).
  - No pulse on reset release, even though the counters sit at (0,0).
  - The first pulse comes after one complete frame.
- Pixel (0,0) after reset release is held for CLK_DIV cycles, identical to every other pixel.
- Reset asserted mid-frame: all state returns to reset values at once. No partial frame_start or pix_en is emitted.
- Counters never exceed H_TOTAL-1 / V_TOTAL-1. Counter registers are sized from the totals; the row/col outputs are zero-extended to 32 bits.

Optional Feature:
VGA_SYNC_DELAY_EN:
- Defined: hsync and vsync pass through one extra CLK register stage, lagging row/col/active by exactly 1 CLK. This aligns them with the renderer's one-cycle registered colour output. The extra stage resets to ~SYNC_POL.
- Undefined: hsync/vsync update on the same edge as the counters, as described above.

Test Plan:
1. Hold RST low for 5 CLKs, then release -> during reset row=0, col=0, active=1, vnotactive=0, hsync=vsync=1, pix_en=0, frame_start=0. First col 0->1 occurs on the 2nd edge after release, with pix_en=1 for 1 CLK.
2. Defaults, run one line -> col 639->640 drops active; hsync=0 exactly while col in 656..751 (192 CLKs); col 799->0 increments row 0->1.
3. Defaults, run one frame -> vnotactive rises on the edge row becomes 480 (col=0); vsync=0 for rows 490..491 (1600 pixels); row 524->0 gives a single 1-CLK frame_start; frame_start period = 840000 CLKs; no frame_start at reset release.
4. Assert RST at row=100, col=300 mid-pixel -> outputs return to reset values without waiting for a CLK edge. After release, the next frame_start occurs 840000 CLKs later.
5. CLK_DIV=1, H_ACTIVE=4, H_FP=1, H_SYNC=1, H_BP=1, V_ACTIVE=2, V_FP=1, V_SYNC=1, V_BP=1 -> pix_en constantly 1; col sequence 0..6 repeating; hsync low only at col=5; frame_start every 35 CLKs.
6. Defaults with VGA_SYNC_DELAY_EN defined -> hsync falls 1 CLK after the edge where col becomes 656 and rises 1 CLK after col becomes 752; row/col/active timing unchanged from scenario 2.
